pipeline_hazard_controller: RTL and testbench

PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

---
 rtl/pipeline_hazard_controller.sv | 123 ++++++++++++
 tb/tb_pipeline_hazard_controller.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_controller.sv
// Hazard control for a 5-stage pipeline: load-use stall, taken-branch flush,
// multi-cycle multiply/divide freeze, operand forwarding and a stall counter.
module pipeline_hazard_controller #(
   parameter int MDU_CYCLES = 4
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic [4:0]  ID_Rs,
   input  logic [4:0]  ID_Rt,
   input  logic        ID_UsesRt,
   input  logic [4:0]  EX_Rs,
   input  logic [4:0]  EX_Rt,
   input  logic        EX_MemRead,
   input  logic        EX_RegWrite,
   input  logic [4:0]  EX_WriteRegister,
   input  logic        EX_IsMulDiv,
   input  logic        EX_BranchTaken,
   input  logic        MEM_RegWrite,
   input  logic [4:0]  MEM_WriteRegister,
   input  logic        WB_RegWrite,
   input  logic [4:0]  WB_WriteRegister,
   output logic        PCWrite,
   output logic        IFID_Write,
   output logic        IDEX_Write,
   output logic        IFID_Flush,
   output logic        IDEX_Bubble,
   output logic [1:0]  ForwardA,
   output logic [1:0]  ForwardB,
   output logic        HiLoWrite,
   output logic        Busy,
   output logic [15:0] StallCount
);

   typedef enum logic [0:0] {RUN, MDU_BUSY} state_t;

   // The start cycle counts as one frozen cycle, so the counter covers the rest.
   localparam logic [3:0] CNT_LOAD = 4'(MDU_CYCLES - 2);

   state_t     state, nextState;
   logic [3:0] cnt, nextCnt;
   logic       loadUse;

   assign loadUse = EX_MemRead && EX_RegWrite && (EX_WriteRegister != 5'd0) &&
                    ((EX_WriteRegister == ID_Rs) ||
                     (ID_UsesRt && (EX_WriteRegister == ID_Rt)));

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state <= RUN;
         cnt   <= 4'd0;
      end else begin
         state <= nextState;
         cnt   <= nextCnt;
      end
   end

   always_comb begin
      nextState   = state;
      nextCnt     = cnt;
      PCWrite     = 1'b1;
      IFID_Write  = 1'b1;
      IDEX_Write  = 1'b1;
      IFID_Flush  = 1'b0;
      IDEX_Bubble = 1'b0;
      HiLoWrite   = 1'b0;
      Busy        = 1'b0;
      case (state)
         RUN: begin
            if (EX_BranchTaken) begin
               IFID_Flush  = 1'b1;
               IDEX_Bubble = 1'b1;
            end else if (EX_IsMulDiv) begin
               nextState  = MDU_BUSY;
               nextCnt    = CNT_LOAD;
               PCWrite    = 1'b0;
               IFID_Write = 1'b0;
               IDEX_Write = 1'b0;
            end else if (loadUse) begin
               PCWrite     = 1'b0;
               IFID_Write  = 1'b0;
               IDEX_Bubble = 1'b1;
            end
         end
         MDU_BUSY: begin
            Busy = 1'b1;
            // Branch and load-use inputs are ignored while the MDU owns EX.
            if (cnt == 4'd0) begin
               HiLoWrite = 1'b1;
               nextState = RUN;
            end else begin
               PCWrite    = 1'b0;
               IFID_Write = 1'b0;
               IDEX_Write = 1'b0;
               nextCnt    = cnt - 4'd1;
            end
         end
         default: nextState = RUN;
      endcase
   end

   // MEM/WB forwarding; the younger (MEM) result wins on a double match.
   function automatic logic [1:0] fwdSel(input logic [4:0] src);
      if (MEM_RegWrite && (MEM_WriteRegister != 5'd0) && (MEM_WriteRegister == src))
         return 2'b10;
      else if (WB_RegWrite && (WB_WriteRegister != 5'd0) && (WB_WriteRegister == src))
         return 2'b01;
      else
         return 2'b00;
   endfunction

   always_comb begin
      ForwardA = fwdSel(EX_Rs);
      ForwardB = fwdSel(EX_Rt);
   end

   always_ff @(posedge Clk) begin
      if (Reset)
         StallCount <= 16'd0;
      else if (!PCWrite && (StallCount != 16'hFFFF))
         StallCount <= StallCount + 16'd1;
   end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed bench for pipeline_hazard_controller (MDU_CYCLES = 4).
module tb_pipeline_hazard_controller;

   logic        Clk = 1'b0;
   logic        Reset;
   logic [4:0]  ID_Rs, ID_Rt, EX_Rs, EX_Rt;
   logic        ID_UsesRt;
   logic        EX_MemRead, EX_RegWrite, EX_IsMulDiv, EX_BranchTaken;
   logic [4:0]  EX_WriteRegister, MEM_WriteRegister, WB_WriteRegister;
   logic        MEM_RegWrite, WB_RegWrite;
   logic        PCWrite, IFID_Write, IDEX_Write, IFID_Flush, IDEX_Bubble;
   logic [1:0]  ForwardA, ForwardB;
   logic        HiLoWrite, Busy;
   logic [15:0] StallCount;

   int nChecks = 0;
   int nFails  = 0;

   pipeline_hazard_controller #(.MDU_CYCLES(4)) dut (
      .Clk(Clk), .Reset(Reset),
      .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
      .EX_Rs(EX_Rs), .EX_Rt(EX_Rt),
      .EX_MemRead(EX_MemRead), .EX_RegWrite(EX_RegWrite),
      .EX_WriteRegister(EX_WriteRegister), .EX_IsMulDiv(EX_IsMulDiv),
      .EX_BranchTaken(EX_BranchTaken),
      .MEM_RegWrite(MEM_RegWrite), .MEM_WriteRegister(MEM_WriteRegister),
      .WB_RegWrite(WB_RegWrite), .WB_WriteRegister(WB_WriteRegister),
      .PCWrite(PCWrite), .IFID_Write(IFID_Write), .IDEX_Write(IDEX_Write),
      .IFID_Flush(IFID_Flush), .IDEX_Bubble(IDEX_Bubble),
      .ForwardA(ForwardA), .ForwardB(ForwardB),
      .HiLoWrite(HiLoWrite), .Busy(Busy), .StallCount(StallCount)
   );

   always #5 Clk = ~Clk;

   task automatic idle();
      ID_Rs = 5'd0; ID_Rt = 5'd0; ID_UsesRt = 1'b0;
      EX_Rs = 5'd0; EX_Rt = 5'd0;
      EX_MemRead = 1'b0; EX_RegWrite = 1'b0; EX_WriteRegister = 5'd0;
      EX_IsMulDiv = 1'b0; EX_BranchTaken = 1'b0;
      MEM_RegWrite = 1'b0; MEM_WriteRegister = 5'd0;
      WB_RegWrite = 1'b0; WB_WriteRegister = 5'd0;
   endtask

   // Drive point: just after a rising edge. Checks happen at +3 more.
   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic doReset();
      Reset = 1'b1;
      idle();
      tick();
      Reset = 1'b0;
   endtask

   task automatic test_reset();
      doReset();
      #3;
      nChecks++;
      if ({PCWrite, IFID_Write, IDEX_Write, IFID_Flush, IDEX_Bubble, HiLoWrite, Busy} !== 7'b1110000) begin
         nFails++;
         $display("FAIL reset_ctrl: got %b expected 1110000",
                  {PCWrite, IFID_Write, IDEX_Write, IFID_Flush, IDEX_Bubble, HiLoWrite, Busy});
      end
      nChecks++;
      if ({ForwardA, ForwardB} !== 4'b0000) begin
         nFails++;
         $display("FAIL reset_fwd: got %b expected 0000", {ForwardA, ForwardB});
      end
      nChecks++;
      if (StallCount !== 16'd0) begin
         nFails++;
         $display("FAIL reset_stallcnt: got %0d expected 0", StallCount);
      end
   endtask

   task automatic test_load_use();
      doReset();
      EX_MemRead = 1'b1; EX_RegWrite = 1'b1; EX_WriteRegister = 5'd8; ID_Rs = 5'd8;
      #3;
      nChecks++;
      if ({PCWrite, IFID_Write, IDEX_Write, IDEX_Bubble, IFID_Flush} !== 5'b00110) begin
         nFails++;
         $display("FAIL loaduse_rs: got %b expected 00110",
                  {PCWrite, IFID_Write, IDEX_Write, IDEX_Bubble, IFID_Flush});
      end
      tick();
      idle();
      #3;
      nChecks++;
      if (StallCount !== 16'd1 || PCWrite !== 1'b1) begin
         nFails++;
         $display("FAIL loaduse_count: got cnt=%0d pc=%b expected cnt=1 pc=1", StallCount, PCWrite);
      end
      // Destination r0 never hazards.
      EX_MemRead = 1'b1; EX_RegWrite = 1'b1; EX_WriteRegister = 5'd0; ID_Rs = 5'd0;
      #1;
      nChecks++;
      if (PCWrite !== 1'b1 || IDEX_Bubble !== 1'b0) begin
         nFails++;
         $display("FAIL loaduse_r0: got pc=%b bub=%b expected pc=1 bub=0", PCWrite, IDEX_Bubble);
      end
      // Rt match only counts when the ID instruction reads Rt.
      EX_WriteRegister = 5'd9; ID_Rs = 5'd3; ID_Rt = 5'd9; ID_UsesRt = 1'b0;
      #1;
      nChecks++;
      if (PCWrite !== 1'b1) begin
         nFails++;
         $display("FAIL loaduse_rt_unused: got pc=%b expected 1", PCWrite);
      end
      ID_UsesRt = 1'b1;
      #1;
      nChecks++;
      if (PCWrite !== 1'b0 || IDEX_Bubble !== 1'b1) begin
         nFails++;
         $display("FAIL loaduse_rt: got pc=%b bub=%b expected pc=0 bub=1", PCWrite, IDEX_Bubble);
      end
      tick();
      idle();
      #3;
      nChecks++;
      if (StallCount !== 16'd2) begin
         nFails++;
         $display("FAIL loaduse_count2: got %0d expected 2", StallCount);
      end
   endtask

   task automatic test_muldiv();
      logic [4:0] expPc, expHilo, expBusy;
      expPc   = 5'b11000;
      expHilo = 5'b01000;
      expBusy = 5'b01110;
      doReset();
      for (int i = 0; i < 5; i++) begin
         idle();
         if (i == 0) EX_IsMulDiv = 1'b1;
         // A taken branch during the freeze must be ignored.
         if (i == 1) EX_BranchTaken = 1'b1;
         #3;
         nChecks++;
         if (PCWrite !== expPc[i] || HiLoWrite !== expHilo[i] || Busy !== expBusy[i] ||
             IFID_Flush !== 1'b0 || IFID_Write !== expPc[i] || IDEX_Write !== expPc[i]) begin
            nFails++;
            $display("FAIL muldiv_cycle%0d: got pc=%b ifid=%b idex=%b hilo=%b busy=%b flush=%b expected pc=%b ifid=%b idex=%b hilo=%b busy=%b flush=0",
                     i, PCWrite, IFID_Write, IDEX_Write, HiLoWrite, Busy, IFID_Flush,
                     expPc[i], expPc[i], expPc[i], expHilo[i], expBusy[i]);
         end
         tick();
      end
      idle();
      nChecks++;
      if (StallCount !== 16'd3) begin
         nFails++;
         $display("FAIL muldiv_stallcnt: got %0d expected 3", StallCount);
      end
   endtask

   task automatic test_priority();
      doReset();
      EX_BranchTaken = 1'b1; EX_IsMulDiv = 1'b1;
      EX_MemRead = 1'b1; EX_RegWrite = 1'b1; EX_WriteRegister = 5'd4; ID_Rs = 5'd4;
      #3;
      nChecks++;
      if ({IFID_Flush, IDEX_Bubble, PCWrite, IFID_Write, IDEX_Write, Busy} !== 6'b111110) begin
         nFails++;
         $display("FAIL priority: got %b expected 111110",
                  {IFID_Flush, IDEX_Bubble, PCWrite, IFID_Write, IDEX_Write, Busy});
      end
      tick();
      idle();
      #3;
      nChecks++;
      if (Busy !== 1'b0 || PCWrite !== 1'b1 || StallCount !== 16'd0) begin
         nFails++;
         $display("FAIL priority_state: got busy=%b pc=%b cnt=%0d expected busy=0 pc=1 cnt=0",
                  Busy, PCWrite, StallCount);
      end
   endtask

   task automatic test_forwarding();
      idle();
      EX_Rs = 5'd5; EX_Rt = 5'd5;
      MEM_RegWrite = 1'b1; MEM_WriteRegister = 5'd5;
      WB_RegWrite = 1'b1; WB_WriteRegister = 5'd5;
      #1;
      nChecks++;
      if (ForwardA !== 2'b10 || ForwardB !== 2'b10) begin
         nFails++;
         $display("FAIL fwd_both: got A=%b B=%b expected A=10 B=10", ForwardA, ForwardB);
      end
      MEM_RegWrite = 1'b0;
      #1;
      nChecks++;
      if (ForwardA !== 2'b01 || ForwardB !== 2'b01) begin
         nFails++;
         $display("FAIL fwd_wb: got A=%b B=%b expected A=01 B=01", ForwardA, ForwardB);
      end
      EX_Rs = 5'd0; EX_Rt = 5'd0; MEM_RegWrite = 1'b1;
      MEM_WriteRegister = 5'd0; WB_WriteRegister = 5'd0;
      #1;
      nChecks++;
      if (ForwardA !== 2'b00 || ForwardB !== 2'b00) begin
         nFails++;
         $display("FAIL fwd_r0: got A=%b B=%b expected A=00 B=00", ForwardA, ForwardB);
      end
      EX_Rs = 5'd7; EX_Rt = 5'd12; MEM_WriteRegister = 5'd12; WB_WriteRegister = 5'd7;
      #1;
      nChecks++;
      if (ForwardA !== 2'b01 || ForwardB !== 2'b10) begin
         nFails++;
         $display("FAIL fwd_split: got A=%b B=%b expected A=01 B=10", ForwardA, ForwardB);
      end
      idle();
   endtask

   task automatic test_reset_mid();
      doReset();
      EX_IsMulDiv = 1'b1;
      tick();
      idle();
      tick();
      Reset = 1'b1;
      #3;
      nChecks++;
      if (Busy !== 1'b1) begin
         nFails++;
         $display("FAIL rstmid_busy: got %b expected 1", Busy);
      end
      tick();
      Reset = 1'b0;
      #3;
      nChecks++;
      if (Busy !== 1'b0 || PCWrite !== 1'b1 || HiLoWrite !== 1'b0 || StallCount !== 16'd0) begin
         nFails++;
         $display("FAIL rstmid_run: got busy=%b pc=%b hilo=%b cnt=%0d expected busy=0 pc=1 hilo=0 cnt=0",
                  Busy, PCWrite, HiLoWrite, StallCount);
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         #3;
         nChecks++;
         if (HiLoWrite !== 1'b0 || Busy !== 1'b0) begin
            nFails++;
            $display("FAIL rstmid_nohilo%0d: got hilo=%b busy=%b expected 0 0", i, HiLoWrite, Busy);
         end
      end
   endtask

   task automatic test_saturation();
      doReset();
      EX_MemRead = 1'b1; EX_RegWrite = 1'b1; EX_WriteRegister = 5'd8; ID_Rs = 5'd8;
      repeat (70000) @(posedge Clk);
      #1;
      nChecks++;
      if (StallCount !== 16'hFFFF) begin
         nFails++;
         $display("FAIL sat_hold: got %h expected ffff", StallCount);
      end
      idle();
      tick();
      nChecks++;
      if (StallCount !== 16'hFFFF) begin
         nFails++;
         $display("FAIL sat_after: got %h expected ffff", StallCount);
      end
   endtask

   initial begin
      Reset = 1'b1;
      idle();
      test_reset();
      test_load_use();
      test_muldiv();
      test_priority();
      test_forwarding();
      test_reset_mid();
      test_saturation();
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
